// File: rtl/fwd_sel_ctrl.sv
// Forwarding/hazard controller for the 5-stage pipeline: EX operand mux4 selects,
// load-use stall generation and a saturating stall-cycle counter.
module fwd_sel_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        ex_sel_a,
    output logic [1:0]        ex_sel_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Shadow of in-flight destinations. The retire entry is not stored: a W match
    // already selects the retire latch, so nothing would ever read it.
    logic              r_e_we, r_e_load, r_m_we, r_w_we;
    logic [REG_AW-1:0] r_e_rd, r_m_rd, r_w_rd;
    logic [1:0]        r_sel_a, r_sel_b;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_stall, w_accept, w_hit_rs, w_hit_rt;
    logic [1:0]        w_sel_a, w_sel_b;

    function automatic logic [1:0] f_sel(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              e_we,
        input logic [REG_AW-1:0] e_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_we,
        input logic [REG_AW-1:0] w_rd
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (used && (src != '0)) begin
            if (e_we && (e_rd == src))      sel = 2'd1;
            else if (m_we && (m_rd == src)) sel = 2'd2;
            else if (w_we && (w_rd == src)) sel = 2'd3;
        end
        return sel;
    endfunction

    always_comb begin
        w_hit_rs = id_rs_used && (id_rs == r_e_rd);
        w_hit_rt = id_rt_used && (id_rt == r_e_rd);
        w_stall  = id_valid && !flush && r_e_we && r_e_load && (r_e_rd != '0)
                   && (w_hit_rs || w_hit_rt);
        w_accept = id_valid && !w_stall && !flush;
        w_sel_a  = f_sel(id_rs_used, id_rs, r_e_we, r_e_rd, r_m_we, r_m_rd, r_w_we, r_w_rd);
        w_sel_b  = f_sel(id_rt_used, id_rt, r_e_we, r_e_rd, r_m_we, r_m_rd, r_w_we, r_w_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_we      <= 1'b0;
            r_e_rd      <= '0;
            r_e_load    <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_rd      <= '0;
            r_w_we      <= 1'b0;
            r_w_rd      <= '0;
            r_sel_a     <= 2'd0;
            r_sel_b     <= 2'd0;
            r_stall_cnt <= '0;
        end else begin
            r_w_we <= r_m_we;
            r_w_rd <= r_m_rd;
            r_m_we <= r_e_we;
            r_m_rd <= r_e_rd;
            if (w_accept) begin
                r_e_we   <= id_wr_en;
                r_e_rd   <= id_rd;
                r_e_load <= id_is_load;
                r_sel_a  <= w_sel_a;
                r_sel_b  <= w_sel_b;
            end else begin
                r_e_we   <= 1'b0;
                r_e_rd   <= '0;
                r_e_load <= 1'b0;
                r_sel_a  <= 2'd0;
                r_sel_b  <= 2'd0;
            end
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall     = w_stall;
    assign ex_sel_a  = r_sel_a;
    assign ex_sel_b  = r_sel_b;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: forwarding distances, priority, load-use stall,
// flush, mid-run reset and counter saturation.
module tb_fwd_sel_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        stall;
    logic [1:0]  ex_sel_a, ex_sel_b;
    logic [31:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fwd_sel_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
        .flush(flush), .stall(stall),
        .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; leaves time 1 unit later for combinational checks.
    task automatic drv(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic we,
                       input logic [4:0] rd, input logic ld, input logic fl);
        @(negedge clk);
        id_valid = v;  id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_wr_en = we; id_rd = rd; id_is_load = ld;  flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_wr_en = 0; id_rd = 0; id_is_load = 0; flush = 0;
        tick(); tick();
        @(negedge clk); rst = 1'b0; #1;
        chk("reset_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("reset_sel_b", {30'd0, ex_sel_b}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_cnt", stall_cnt, 32'd0);

        // Distance 1: add r3, then read rs=r3, rt=r1
        drv(1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0); tick();
        drv(1, 5'd3, 1, 5'd1, 1, 1, 5'd8, 0, 0);
        chk("d1_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("d1_sel_a", {30'd0, ex_sel_a}, 32'd1);
        chk("d1_sel_b", {30'd0, ex_sel_b}, 32'd0);
        nops(4);

        // Distance 2
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 0); tick();
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0); tick();
        drv(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0); tick();
        chk("d2_sel_a", {30'd0, ex_sel_a}, 32'd2);
        nops(4);

        // Distance 3
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 0); tick();
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0); tick();
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 0, 0); tick();
        drv(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0); tick();
        chk("d3_sel_a", {30'd0, ex_sel_a}, 32'd3);
        nops(4);

        // Distance 4: out of the forwarding window
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd5, 0, 0); tick();
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 0); tick();
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 0, 0); tick();
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd11, 0, 0); tick();
        drv(1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0); tick();
        chk("d4_sel_a", {30'd0, ex_sel_a}, 32'd0);
        nops(4);

        // Youngest producer wins
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0); tick();
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 0); tick();
        drv(1, 5'd7, 1, 5'd7, 1, 0, 5'd0, 0, 0); tick();
        chk("prio_sel_a", {30'd0, ex_sel_a}, 32'd1);
        chk("prio_sel_b", {30'd0, ex_sel_b}, 32'd1);
        nops(4);

        // Load-use: lw r4; add reads rt=r4
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 0); tick();
        drv(1, 5'd2, 1, 5'd4, 1, 1, 5'd6, 0, 0);
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lu_cnt", stall_cnt, 32'd1);
        chk("lu_bubble_sel_b", {30'd0, ex_sel_b}, 32'd0);
        chk("lu_stall_once", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_sel_b", {30'd0, ex_sel_b}, 32'd2);
        chk("lu_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("lu_cnt_hold", stall_cnt, 32'd1);
        nops(4);

        // r0 never stalls or forwards
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 1, 0); tick();
        drv(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0);
        chk("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("r0_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("r0_sel_b", {30'd0, ex_sel_b}, 32'd0);
        nops(4);

        // Flush overrides hazard
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 0); tick();
        drv(1, 5'd4, 1, 5'd0, 0, 1, 5'd6, 0, 1);
        chk("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("fl_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("fl_cnt", stall_cnt, 32'd1);
        nops(1);

        // Reset discards in-flight r6
        drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd6, 0, 0); tick();
        @(negedge clk); rst = 1'b1; id_valid = 0; #1;
        tick();
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_sel_a", {30'd0, ex_sel_a}, 32'd0);
        chk("rst_sel_b", {30'd0, ex_sel_b}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        drv(1, 5'd6, 1, 5'd6, 1, 0, 5'd0, 0, 0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("rst_fwd_a", {30'd0, ex_sel_a}, 32'd0);
        chk("rst_fwd_b", {30'd0, ex_sel_b}, 32'd0);
        nops(4);

        // Saturation from FFFFFFFE
        @(negedge clk);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        for (int k = 0; k < 3; k++) begin
            drv(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 0); tick();
            drv(1, 5'd0, 0, 5'd4, 1, 0, 5'd0, 0, 0);
            chk("sat_stall", {31'd0, stall}, 32'd1);
            tick();
            chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);
            tick();
        end
        nops(2);
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipeline.
- Generates the 2-bit `choose` codes for the two EX-stage operand mux4 instances (WIDTH=32), the far end of that select interface.
- Detects load-use hazards, requests a one-cycle stall, and counts stall cycles.
- Tracks the destination registers of in-flight instructions in an internal EX/MEM/WB/retire shadow pipeline.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  source register A of ID instruction.
- id_rt  in  REG_AW  source register B of ID instruction.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- id_wr_en  in  1  ID instruction writes a register.
- id_rd  in  REG_AW  destination register of ID instruction.
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  squash the ID instruction (taken branch/jump).
- stall  out  1  combinational; hold PC and IF/ID, bubble into EX.
- ex_sel_a  out  2  registered choose for operand-A mux4.
- ex_sel_b  out  2  registered choose for operand-B mux4.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst=1 at the edge): all shadow entries are invalid (we=0, rd=0, load=0); ex_sel_a=ex_sel_b=2'd0; stall_cnt=0. stall reads 0 while the shadow is clear.
- Shadow pipeline:
  - Four entries {we, rd, load}: E (in EX), M (in MEM), W (in WB), R (retire latch, one cycle past WB).
  - Each edge: R<=W, W<=M, M<=E.
  - E <= ID fields if id_valid & ~stall & ~flush; otherwise E <= bubble (we=0).
- Choose encoding (must match the mux4 data1..data4 wiring):
  - 0 = regfile.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB result.
  - 3 = retire latch value.
- Select computation (at ID, registered into ex_sel_* on the same edge as E):
  - For operand A: if id_rs_used and id_rs != 0, compare against E, then M, then W. The youngest match wins.
  - E match -> 1. M match -> 2. W match -> 3. No match -> 0.
  - Operand B is computed identically using id_rt and id_rt_used.
  - Register 0 never forwards; it always selects 0.
- Load-use hazard: stall = id_valid & ~flush & E.we & E.load & (E.rd != 0) & ((id_rs_used & id_rs==E.rd) | (id_rt_used & id_rt==E.rd)).
- On a stall edge: a bubble enters E and ex_sel_a/ex_sel_b are loaded with 0. Next cycle the load is in M, so the re-evaluated ID instruction gets sel=2. Stall lasts exactly one cycle per hazard.
- Flush: has priority over stall (stall forced 0); bubble enters E; sels are loaded with 0.
- stall_cnt: increments by 1 on each edge where stall=1; saturates at all-ones (no wrap).
- Reset mid-operation: all in-flight tracking is discarded with no residual forwarding. The first instruction after reset sees sel=0.
- Latency: ex_sel_* are valid in the cycle the instruction occupies EX, i.e. one edge after it was presented at ID.

Test Plan:
- Reset -> ex_sel_a=0, ex_sel_b=0, stall=0, stall_cnt=0. Apply I1 (add r3), then I2 reading rs=r3 -> in I2's EX cycle ex_sel_a=1, ex_sel_b=0.
- Distance 2 and 3: I1 writes r5, one unrelated instruction, then I3 rs=r5 -> ex_sel_a=2. With two gaps -> ex_sel_a=3. With three gaps -> 0.
- Priority: I1 and I2 both write r7; I3 reads rs=rt=r7 -> ex_sel_a=ex_sel_b=1 (youngest wins, not 2).
- Load-use: lw r4, then add reading rt=r4 -> stall=1 for exactly one cycle; stall_cnt=1; next cycle ex_sel_b=2 when add reaches EX. A write to r0 followed by a read of r0 -> no stall, sel=0.
- Flush and hazard together: lw r4 in EX, ID reads r4 with flush=1 -> stall=0, bubble enters EX, stall_cnt unchanged. Assert rst after the bubble -> all sels 0 and the next dependent instruction gets sel=0.
- Saturation: preload stall_cnt to 32'hFFFFFFFE via repeated hazards (or force in the bench), then apply 3 stalls -> stall_cnt=32'hFFFFFFFF and it holds.
